dot_prod_unit: RTL and testbench

- Downstream consumer of the decoder's dot-product controls. Takes the per-lane PE multiply outputs, reduces them through a pipelined adder tree, and accumulates partial sums across instructions.
- On a "shift" instruction, pushes the finished dot product into a LANES-wide result vector. That vector is written to data BRAM when r_select=1.
- Supports matrix-vector products: one dot product per matrix row, shifted into the result vector.

---
 rtl/dot_prod_unit_pkg.sv | 10 +
 rtl/dot_prod_unit_add_tree_pipe.sv | 84 ++++++++
 rtl/dot_prod_unit.sv | 86 ++++++++
 tb/tb_dot_prod_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dot_prod_unit_pkg.sv
// dot_prod_unit_pkg: shared defaults and types for the dot-product unit
package dot_prod_unit_pkg;
    localparam int LANES_DEF      = 8;
    localparam int DATA_WIDTH_DEF = 32;
    typedef logic [LANES_DEF-1:0][DATA_WIDTH_DEF-1:0] lane_vec_t;
    typedef struct packed {
        logic valid;
        logic shift;
    } beat_t;
endpackage

// File: rtl/dot_prod_unit_add_tree_pipe.sv
// add_tree_pipe: pipelined pairwise reduction of LANES words with sideband and overflow
//   clk, rstn   clock, synchronous active-low reset
//   clear       synchronous flush of all stages
//   in_beat     sideband (valid, shift) entering with prod_in
//   prod_in     lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sum_out     reduced sum, aligned with beat_out
//   beat_out    sideband leaving the last stage
//   ovf_out     registered pulse: a valid add overflowed somewhere in the tree
//   busy_out    any stage holds a valid beat
module add_tree_pipe
    import dot_prod_unit_pkg::*;
#(
    parameter int LANES      = LANES_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clear,
    input  beat_t                       in_beat,
    input  logic [LANES*DATA_WIDTH-1:0] prod_in,
    output logic [DATA_WIDTH-1:0]       sum_out,
    output beat_t                       beat_out,
    output logic                        ovf_out,
    output logic                        busy_out
);
    localparam int TREE_DEPTH = $clog2(LANES);
    localparam int MSB        = DATA_WIDTH - 1;

    // Heap-ordered tree: nodes 0..LANES-2 are registered sums, the rest are the raw lanes.
    // A complete tree keeps every path the same length, so one register per node aligns the levels.
    logic [DATA_WIDTH-1:0] node  [2*LANES-1];
    logic [DATA_WIDTH-1:0] sum_d [LANES-1];
    logic [DATA_WIDTH-1:0] sum_q [LANES-1];
    beat_t                 bt_d  [TREE_DEPTH];
    beat_t                 bt_q  [TREE_DEPTH];
    logic [TREE_DEPTH-1:0] vin;
    logic [LANES-2:0]      ov;
    logic                  ovf_d, ovf_q;

    always_comb begin
        for (int i = 0; i < LANES-1; i++) node[i] = sum_q[i];
        for (int i = 0; i < LANES; i++) node[LANES-1+i] = prod_in[i*DATA_WIDTH +: DATA_WIDTH];
        bt_d[0] = in_beat;
        vin[0]  = in_beat.valid;
        for (int s = 1; s < TREE_DEPTH; s++) begin
            bt_d[s] = bt_q[s-1];
            vin[s]  = bt_q[s-1].valid;
        end
    end

    for (genvar i = 0; i < LANES-1; i++) begin : g_node
        // level 1 sits just above the lanes, level TREE_DEPTH is the root
        localparam int LVL = TREE_DEPTH + 1 - $clog2(i + 2);
        logic [DATA_WIDTH-1:0] a, b;
        assign a        = node[2*i+1];
        assign b        = node[2*i+2];
        assign sum_d[i] = a + b;
        // only adds carrying a valid beat may raise overflow
        assign ov[i]    = vin[LVL-1] && (a[MSB] == b[MSB]) && (sum_d[i][MSB] != a[MSB]);
    end

    assign ovf_d = |ov;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            sum_q <= '{default: '0};
            bt_q  <= '{default: '0};
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            bt_q  <= bt_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        busy_out = 1'b0;
        for (int s = 0; s < TREE_DEPTH; s++) busy_out = busy_out | bt_q[s].valid;
    end

    assign sum_out  = sum_q[0];
    assign beat_out = bt_q[TREE_DEPTH-1];
    assign ovf_out  = ovf_q;
endmodule

// File: rtl/dot_prod_unit.sv
// dot_prod_unit: adder-tree reduction, cross-instruction accumulation and result-vector shifting
//   clk, rstn      clock, synchronous active-low reset
//   in_valid       one strobe per issued instruction
//   dot_prod_en    beat enters the tree only when set with in_valid
//   shift          1 = finish dot product into lane 0, 0 = accumulate
//   prod_in        PE products, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   clear          synchronous flush of accumulator, result vector, pipeline and ovf
//   acc_out        current accumulator
//   r_vec_out      result vector, lane 0 = most recent dot product
//   out_valid      one-cycle pulse when a result lands in r_vec_out
//   busy           a valid beat is in the tree or accumulate stage
//   ovf            sticky signed overflow
module dot_prod_unit
    import dot_prod_unit_pkg::*;
#(
    parameter int LANES      = LANES_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    input  logic                        dot_prod_en,
    input  logic                        shift,
    input  logic [LANES*DATA_WIDTH-1:0] prod_in,
    input  logic                        clear,
    output logic [DATA_WIDTH-1:0]       acc_out,
    output logic [LANES*DATA_WIDTH-1:0] r_vec_out,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        ovf
);
    localparam int MSB = DATA_WIDTH - 1;

    beat_t                       in_beat, t_beat;
    logic [DATA_WIDTH-1:0]       t_sum, sum;
    logic                        t_ovf, acc_ov, fin;
    logic [DATA_WIDTH-1:0]       acc_d, acc_q;
    logic [LANES*DATA_WIDTH-1:0] r_vec_d, r_vec_q;
    logic                        out_valid_d, out_valid_q;
    logic                        ovf_d, ovf_q;

    // a beat presented together with clear is dropped
    assign in_beat = '{valid: in_valid && dot_prod_en && !clear, shift: shift};

    add_tree_pipe #(.LANES(LANES), .DATA_WIDTH(DATA_WIDTH)) u_tree (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (clear),
        .in_beat  (in_beat),
        .prod_in  (prod_in),
        .sum_out  (t_sum),
        .beat_out (t_beat),
        .ovf_out  (t_ovf),
        .busy_out (busy)
    );

    // acc_q already holds every earlier beat's update, so back-to-back beats need no bubble
    always_comb begin
        sum         = acc_q + t_sum;
        acc_ov      = (acc_q[MSB] == t_sum[MSB]) && (sum[MSB] != acc_q[MSB]);
        fin         = t_beat.valid && t_beat.shift;
        acc_d       = clear ? '0 : !t_beat.valid ? acc_q : t_beat.shift ? '0 : sum;
        r_vec_d     = clear ? '0 : fin ? {r_vec_q[(LANES-1)*DATA_WIDTH-1:0], sum} : r_vec_q;
        out_valid_d = !clear && fin;
        ovf_d       = !clear && (ovf_q || t_ovf || (t_beat.valid && acc_ov));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q       <= '0;
            r_vec_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            r_vec_q     <= r_vec_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign acc_out   = acc_q;
    assign r_vec_out = r_vec_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_dot_prod_unit.sv
// tb_dot_prod_unit: directed self-checking bench for dot_prod_unit with LANES=4
module tb_dot_prod_unit;
    logic         clk = 1'b0;
    logic         rstn, in_valid, dot_prod_en, shift, clear;
    logic [127:0] prod_in;
    logic [31:0]  acc_out;
    logic [127:0] r_vec_out;
    logic         out_valid, busy, ovf;
    int           checks = 0;
    int           failures = 0;
    int           pulses = 0;
    logic [127:0] rv;

    dot_prod_unit #(.LANES(4), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .dot_prod_en (dot_prod_en),
        .shift       (shift),
        .prod_in     (prod_in),
        .clear       (clear),
        .acc_out     (acc_out),
        .r_vec_out   (r_vec_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pv(input logic [31:0] l3, l2, l1, l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        pulses += int'(out_valid);
    endtask

    task automatic drive(input logic [127:0] p, input logic sh, input logic en);
        in_valid    = 1'b1;
        dot_prod_en = en;
        shift       = sh;
        prod_in     = p;
        tick();
        in_valid    = 1'b0;
        dot_prod_en = 1'b0;
        shift       = 1'b0;
    endtask

    task automatic flush_check(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_acc"}, 128'(acc_out), 128'd0);
        chk({tag, "_rvec"}, r_vec_out, 128'd0);
        chk({tag, "_oval"}, 128'(out_valid), 128'd0);
        pulses = 0;
        repeat (4) tick();
        chk({tag, "_nopulse"}, 128'(pulses), 128'd0);
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; dot_prod_en = 1'b0; shift = 1'b0; clear = 1'b0; prod_in = '0;
        repeat (3) tick();
        chk("rst_acc", 128'(acc_out), 128'd0);
        chk("rst_rvec", r_vec_out, 128'd0);
        chk("rst_oval", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ovf", 128'(ovf), 128'd0);
        rstn = 1'b1;
        tick();

        // single shift beat, latency 3
        drive(pv(4, 3, 2, 1), 1'b1, 1'b1);
        chk("t1_busy", 128'(busy), 128'd1);
        tick();
        chk("t1_early", 128'(out_valid), 128'd0);
        tick();
        chk("t1_oval", 128'(out_valid), 128'd1);
        chk("t1_lane0", r_vec_out, pv(0, 0, 0, 10));
        chk("t1_acc", 128'(acc_out), 128'd0);
        chk("t1_ovf", 128'(ovf), 128'd0);
        tick();
        chk("t1_oval_off", 128'(out_valid), 128'd0);
        chk("t1_idle", 128'(busy), 128'd0);

        // accumulate then shift back to back
        pulses = 0;
        drive(pv(1, 1, 1, 1), 1'b0, 1'b1);
        drive(pv(2, 2, 2, 2), 1'b1, 1'b1);
        repeat (4) tick();
        chk("t2_pulses", 128'(pulses), 128'd1);
        chk("t2_rvec", r_vec_out, pv(0, 0, 10, 12));
        chk("t2_acc", 128'(acc_out), 128'd0);

        // five shifts wrap the result vector
        pulses = 0;
        for (int k = 1; k <= 5; k++) drive(pv(0, 0, 0, 32'(k)), 1'b1, 1'b1);
        repeat (3) tick();
        chk("t3_pulses", 128'(pulses), 128'd5);
        chk("t3_rvec", r_vec_out, pv(2, 3, 4, 5));

        // disabled beat is ignored
        rv = r_vec_out;
        pulses = 0;
        drive(pv(9, 9, 9, 9), 1'b1, 1'b0);
        chk("t4_busy", 128'(busy), 128'd0);
        repeat (3) tick();
        chk("t4_rvec", r_vec_out, rv);
        chk("t4_acc", 128'(acc_out), 128'd0);
        chk("t4_pulses", 128'(pulses), 128'd0);

        // accumulator visible, then folded into a shift
        drive(pv(0, 0, 2, 1), 1'b0, 1'b1);
        repeat (2) tick();
        chk("t5_acc", 128'(acc_out), 128'd3);
        drive(pv(0, 0, 0, 4), 1'b1, 1'b1);
        repeat (2) tick();
        chk("t5_rvec", r_vec_out, pv(3, 4, 5, 7));
        chk("t5_acc0", 128'(acc_out), 128'd0);

        // tree overflow is sticky until clear
        chk("t6_ovf_pre", 128'(ovf), 128'd0);
        drive(pv(0, 0, 1, 32'h7FFFFFFF), 1'b1, 1'b1);
        repeat (2) tick();
        chk("t6_lane0", 128'(r_vec_out[31:0]), 128'h80000000);
        chk("t6_ovf", 128'(ovf), 128'd1);
        drive(pv(0, 0, 0, 1), 1'b1, 1'b1);
        repeat (2) tick();
        chk("t6_lane0b", 128'(r_vec_out[31:0]), 128'd1);
        chk("t6_sticky", 128'(ovf), 128'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_clr_ovf", 128'(ovf), 128'd0);
        chk("t6_clr_rvec", r_vec_out, 128'd0);

        // accumulator overflow
        drive(pv(0, 0, 0, 32'h7FFFFFFF), 1'b0, 1'b1);
        drive(pv(0, 0, 0, 1), 1'b1, 1'b1);
        repeat (2) tick();
        chk("t7_lane0", 128'(r_vec_out[31:0]), 128'h80000000);
        chk("t7_ovf", 128'(ovf), 128'd1);

        // clear one cycle after a shift beat enters
        drive(pv(0, 0, 0, 6), 1'b0, 1'b1);
        repeat (2) tick();
        chk("t8_acc", 128'(acc_out), 128'd6);
        pulses = 0;
        drive(pv(1, 1, 1, 1), 1'b1, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t8_ovf", 128'(ovf), 128'd0);
        flush_check("t8");

        // same with rstn
        drive(pv(0, 0, 0, 3), 1'b1, 1'b1);
        drive(pv(0, 0, 0, 6), 1'b0, 1'b1);
        repeat (2) tick();
        chk("t9_acc", 128'(acc_out), 128'd6);
        chk("t9_rvec", r_vec_out, pv(0, 0, 0, 3));
        drive(pv(1, 1, 1, 1), 1'b1, 1'b1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        flush_check("t9");

        // beat presented together with clear is dropped
        in_valid = 1'b1; dot_prod_en = 1'b1; shift = 1'b1; prod_in = pv(1, 1, 1, 1); clear = 1'b1;
        tick();
        in_valid = 1'b0; dot_prod_en = 1'b0; shift = 1'b0; clear = 1'b0;
        flush_check("t10");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
